// File: rtl/mem_cmd_port_gen_if.sv
// Handshake bundle between the external bus, the command port and the transaction FSM.
// valid/ready: a beat moves on a rising edge where both are high; valid may not drop before that.
interface mem_cmd_port_gen_if #(
   parameter int DATA_W = 8
);
   logic              bus_valid;
   logic              bus_ready_o;
   logic [DATA_W-1:0] bus_data;
   logic              bus_valid_o;
   logic              bus_ready;
   logic [DATA_W-1:0] bus_data_o;
   logic              fsm_valid_o;
   logic              fsm_ready;
   logic [DATA_W-1:0] fsm_data_o;
   logic              fsm_valid;
   logic              fsm_ready_o;
   logic [DATA_W-1:0] fsm_data;

   modport slave (
      input  bus_valid, bus_data, bus_ready, fsm_ready, fsm_valid, fsm_data,
      output bus_ready_o, bus_valid_o, bus_data_o, fsm_valid_o, fsm_data_o, fsm_ready_o
   );

   modport master (
      output bus_valid, bus_data, bus_ready, fsm_ready, fsm_valid, fsm_data,
      input  bus_ready_o, bus_valid_o, bus_data_o, fsm_valid_o, fsm_data_o, fsm_ready_o
   );
endinterface

// File: rtl/mem_cmd_port_gen.sv
// Command port: decodes a header + address, streams WR/RD beats, then requests the ack bus.
// Optional idle watchdog in WR/RD is enabled by defining MEM_CMD_TIMEOUT_EN.
module mem_cmd_port_gen #(
   parameter int DATA_W     = 8,
   parameter int ADDR_BYTES = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   mem_cmd_port_gen_if.slave       io,
   input  logic                    txn_done,
   output logic                    ack_req,
   output logic [1:0]              ack_id,
   input  logic                    ack_grant,
   output logic                    r_w,
   output logic                    ena,
   output logic [8*ADDR_BYTES-1:0] address,
   output logic                    address_valid,
   output logic [8:0]              length,
   output logic                    length_valid,
   output logic                    err,
   output logic [2:0]              dbg_state_o
);
   if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32) || ADDR_BYTES < 1 || ADDR_BYTES > 4
       || TIMEOUT < 1) begin : g_param_check
      $error("mem_cmd_port_gen: illegal parameter set");
   end

   localparam int BPW = DATA_W / 8;

   localparam logic [1:0] OP_RD_KEY = 2'd0;
   localparam logic [1:0] OP_WR_RES = 2'd2;
   localparam logic [1:0] OP_HASH   = 2'd3;
   localparam logic [1:0] ID_SHA    = 2'd1;
   localparam logic [1:0] ID_AES    = 2'd2;
   localparam logic [1:0] ID_CTRL   = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_ADDR, S_WR, S_RD, S_ACK} state_t;

   state_t                  state_q;
   logic                    alive_q;
   logic [1:0]              op_q, src_q;
   logic [8:0]              cnt_q, len_q;
   logic [8*ADDR_BYTES-1:0] addr_q;
   logic                    addr_vld_q, len_vld_q;
   logic                    r_w_q, ena_q, wr_q, ack_req_q;
   logic [1:0]              ack_id_q;
   logic                    fsm_vld_q, bus_vld_q;
   logic [DATA_W-1:0]       fsm_dat_q, bus_dat_q;

   logic       bus_rdy_d, fsm_rdy_d;
   logic       in_xfer_d, fsm_in_xfer_d;
   logic [8:0] len_d;

   // Beat count from the latched header: key reads and SHA traffic move 32 bytes, AES 16.
   always_comb begin
      len_d = 9'd0;
      if (op_q == OP_RD_KEY || src_q == ID_SHA) len_d = 9'(32 / BPW);
      else if (src_q == ID_AES)                 len_d = 9'(16 / BPW);
   end

   // Ready outputs; in WR the bus sees the FSM's ready directly, gated once all beats are in.
   always_comb begin
      bus_rdy_d = 1'b0;
      fsm_rdy_d = 1'b0;
      case (state_q)
         S_IDLE, S_ADDR: bus_rdy_d = alive_q;
         S_WR:           bus_rdy_d = io.fsm_ready && (cnt_q < len_q);
         S_RD:           fsm_rdy_d = (cnt_q < len_q) && (!bus_vld_q || io.bus_ready);
         default:        ;
      endcase
   end

   assign in_xfer_d     = io.bus_valid && bus_rdy_d;
   assign fsm_in_xfer_d = io.fsm_valid && fsm_rdy_d;

`ifdef MEM_CMD_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT + 1);
   logic [IW-1:0] idle_q;
   logic          err_q;
   logic          beat_d;
   assign beat_d = in_xfer_d || fsm_in_xfer_d || (fsm_vld_q && io.fsm_ready)
                   || (bus_vld_q && io.bus_ready);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         alive_q    <= 1'b0;
         op_q       <= 2'd0;
         src_q      <= 2'd0;
         cnt_q      <= 9'd0;
         len_q      <= 9'd0;
         addr_q     <= '0;
         addr_vld_q <= 1'b0;
         len_vld_q  <= 1'b0;
         r_w_q      <= 1'b0;
         ena_q      <= 1'b0;
         wr_q       <= 1'b0;
         ack_req_q  <= 1'b0;
         ack_id_q   <= 2'd0;
         fsm_vld_q  <= 1'b0;
         fsm_dat_q  <= '0;
         bus_vld_q  <= 1'b0;
         bus_dat_q  <= '0;
`ifdef MEM_CMD_TIMEOUT_EN
         idle_q     <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         alive_q    <= 1'b1;
         addr_vld_q <= 1'b0;
         len_vld_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_xfer_d) begin
                  op_q    <= io.bus_data[1:0];
                  src_q   <= io.bus_data[3:2];
                  cnt_q   <= 9'd0;
                  state_q <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (in_xfer_d) begin
                  for (int i = 0; i < ADDR_BYTES; i++) begin
                     if (cnt_q == 9'(i)) addr_q[8*i +: 8] <= io.bus_data[7:0];
                  end
                  if (cnt_q == 9'(ADDR_BYTES - 1)) begin
                     cnt_q      <= 9'd0;
                     len_q      <= len_d;
                     addr_vld_q <= 1'b1;
                     len_vld_q  <= 1'b1;
                     state_q    <= S_HDR;
                  end else begin
                     cnt_q <= cnt_q + 9'd1;
                  end
               end
            end
            S_HDR: begin
               if (op_q == OP_HASH || len_q == 9'd0) begin
                  wr_q     <= 1'b0;
                  ack_id_q <= ID_CTRL;
                  state_q  <= S_ACK;
               end else if (op_q == OP_WR_RES) begin
                  wr_q     <= 1'b1;
                  r_w_q    <= 1'b0;
                  ena_q    <= 1'b1;
                  ack_id_q <= src_q;
                  state_q  <= S_WR;
               end else begin
                  wr_q     <= 1'b0;
                  r_w_q    <= 1'b1;
                  ena_q    <= 1'b1;
                  ack_id_q <= ID_CTRL;
                  state_q  <= S_RD;
               end
            end
            S_WR: begin
               if (in_xfer_d) cnt_q <= cnt_q + 9'd1;
               if (io.fsm_ready) begin
                  fsm_vld_q <= in_xfer_d;
                  fsm_dat_q <= io.bus_data;
               end
               if (cnt_q == len_q && (!fsm_vld_q || io.fsm_ready)) state_q <= S_ACK;
            end
            S_RD: begin
               if (fsm_in_xfer_d) begin
                  cnt_q     <= cnt_q + 9'd1;
                  bus_vld_q <= 1'b1;
                  bus_dat_q <= io.fsm_data;
               end else if (bus_vld_q && io.bus_ready) begin
                  bus_vld_q <= 1'b0;
               end
               if (cnt_q == len_q && (!bus_vld_q || io.bus_ready)) state_q <= S_ACK;
            end
            S_ACK: begin
               if (ack_req_q && ack_grant) begin
                  ack_req_q <= 1'b0;
                  ena_q     <= 1'b0;
                  r_w_q     <= 1'b0;
                  wr_q      <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (!ack_req_q && (!wr_q || txn_done)) begin
                  ack_req_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
`ifdef MEM_CMD_TIMEOUT_EN
         // Watchdog wins over the state updates above when it fires.
         if (state_q == S_WR || state_q == S_RD) begin
            if (beat_d) begin
               idle_q <= '0;
            end else if (idle_q == IW'(TIMEOUT - 1)) begin
               idle_q    <= '0;
               err_q     <= 1'b1;
               ena_q     <= 1'b0;
               r_w_q     <= 1'b0;
               wr_q      <= 1'b0;
               fsm_vld_q <= 1'b0;
               bus_vld_q <= 1'b0;
               state_q   <= S_IDLE;
            end else begin
               idle_q <= idle_q + IW'(1);
            end
         end else begin
            idle_q <= '0;
         end
`endif
      end
   end

`ifdef MEM_CMD_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign io.bus_ready_o = bus_rdy_d;
   assign io.fsm_ready_o = fsm_rdy_d;
   assign io.fsm_valid_o = fsm_vld_q;
   assign io.fsm_data_o  = fsm_dat_q;
   assign io.bus_valid_o = bus_vld_q;
   assign io.bus_data_o  = bus_dat_q;
   assign ack_req        = ack_req_q;
   assign ack_id         = ack_id_q;
   assign r_w            = r_w_q;
   assign ena            = ena_q;
   assign address        = addr_q;
   assign address_valid  = addr_vld_q;
   assign length         = len_q;
   assign length_valid   = len_vld_q;
   assign dbg_state_o    = state_q;
endmodule

// File: doc/mem_cmd_port_gen.md
MEM_CMD_PORT_GEN -- requirements
Module: mem_cmd_port_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bus/FSM data width in bits (legal values 8, 16, 32).
REQ-002 SHALL have parameter ADDR_BYTES, default 3, meaning number of address beats after the header (1..4).
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning idle-handshake cycles before abort (used only with the macro in REQ-030).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 bus_valid / bus_ready_o / bus_data  in / out / in  1 / 1 / DATA_W  inbound bus handshake and data.
REQ-007 bus_valid_o / bus_ready / bus_data_o  out / in / out  1 / 1 / DATA_W  outbound bus handshake and data.
REQ-008 fsm_valid_o / fsm_ready / fsm_data_o  out / in / out  1 / 1 / DATA_W  data to transaction FSM.
REQ-009 fsm_valid / fsm_ready_o / fsm_data  in / out / in  1 / 1 / DATA_W  data from transaction FSM.
REQ-010 txn_done  in  1  FSM transaction complete.
REQ-011 ack_req / ack_id / ack_grant  out / out / in  1 / 2 / 1  ack-bus request, target ID, grant.
REQ-012 r_w / ena  out  1 each  1 = read, 0 = write; ena = operation active.
REQ-013 address / address_valid  out  8*ADDR_BYTES / 1  captured address and 1-cycle strobe.
REQ-014 length / length_valid  out  9 / 1  beat count and 1-cycle strobe.
REQ-015 err  out  1  sticky abort flag.

Function
REQ-016 A beat SHALL transfer only on a rising edge where valid and ready are both high.
REQ-017 States SHALL be IDLE, HDR, ADDR, WR (bus to FSM), RD (FSM to bus) and ACK.
REQ-018 IDLE: bus_ready_o SHALL be high; a header beat SHALL move the block to ADDR.
REQ-019 Header beat SHALL decode bits [7:0] as enc_dec[7], rsvd[6], dest[5:4], source[3:2], opcode[1:0]; upper bits are ignored; opcodes RD_KEY=0, RD_TEXT=1, WR_RES=2, HASH_OP=3; IDs MEM=0, SHA=1, AES=2, CTRL=3.
REQ-020 ADDR: exactly ADDR_BYTES beats, LSB byte first from bits [7:0]; address_valid SHALL pulse on the cycle after the last address beat.
REQ-021 Beat count SHALL be bytes/(DATA_W/8), with 32 bytes for RD_KEY or source SHA, 16 bytes for source AES, and 0 otherwise; length and length_valid SHALL be issued with address_valid.
REQ-022 WR_RES SHALL set r_w=0 and ena=1 and enter WR; RD_KEY and RD_TEXT SHALL set r_w=1 and ena=1 and enter RD; HASH_OP or a 0-length operation SHALL go to ACK(CTRL) with ena=0.
REQ-023 WR: fsm_valid_o and fsm_data_o SHALL be registered copies of the inbound beat; bus_ready_o SHALL equal fsm_ready; the block SHALL exit after `length` beats.
REQ-024 RD: fsm_data SHALL be registered to bus_data_o with bus_valid_o held until accepted; fsm_ready_o SHALL be low while bus_valid_o is high and unaccepted; no beat is lost under backpressure.
REQ-025 ACK: ack_req SHALL assert with ack_id=CTRL after a read or HASH_OP; after a write, ack_id=source and ack_req SHALL assert only once txn_done is high; ack_req SHALL hold until ack_grant, then the block SHALL return to IDLE with ena=0.
REQ-026 A header beat arriving while not in IDLE SHALL NOT be accepted (bus_ready_o low).
REQ-027 Internal beat counter SHALL be 9 bits wide and SHALL NOT wrap within one operation.

Reset
REQ-028 While rst is high: state=IDLE; every output 0 except bus_ready_o=0 (goes to 1 on the first cycle after release); err=0; counters cleared.
REQ-029 Reset asserted mid-operation SHALL abandon the transfer immediately with no ack issued.

Configuration
REQ-030 With macro MEM_CMD_TIMEOUT_EN defined: in WR or RD, TIMEOUT consecutive cycles without a beat SHALL set err=1, drop ena and valids, and return to IDLE with no ack; without the macro: no watchdog, err SHALL be tied to 0.

Verification
REQ-031 DATA_W=8: header 0x06 (WR_RES, src SHA), address 0x12,0x34,0x56 -> address=0x563412, length=32, 32 beats on fsm_data_o, ack_id=1 after txn_done.
REQ-032 Header 0x09 (RD_TEXT, src AES), DATA_W=16 -> length=8, 8 words on bus_data_o, then ack_id=3.
REQ-033 RD with bus_ready toggling every other cycle -> every FSM word appears exactly once, in order.
REQ-034 Header 0x03 (HASH_OP) -> ena stays 0, ack_id=3, back to IDLE after ack_grant.
REQ-035 rst pulsed at WR beat 10 -> all outputs 0, no ack; the next header is accepted normally.
REQ-036 MEM_CMD_TIMEOUT_EN defined, TIMEOUT=4, fsm_valid held low in RD -> err=1 after 4 cycles, state IDLE.
